// File: rtl/sumador_pkg.sv
// ============================================================================
// Module      : sumador_pkg
// Description : Shared types and constants for the adder-result UART sender.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package sumador_pkg;

    localparam int DATA_BITS            = 8;
    localparam int BYTES_PER_FRAME      = 2;
    localparam int DEFAULT_CLKS_PER_BIT = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    // Payload bit for a given byte of the frame: byte0 = sum, byte1 = {7'b0, carry}.
    function automatic logic payload_bit(
        input logic [DATA_BITS-1:0] sum,
        input logic                 carry,
        input logic                 byte_idx,
        input logic [2:0]           bit_idx
    );
        logic w_bit;
        if (!byte_idx) begin
            w_bit = sum[bit_idx];
        end else begin
            w_bit = (bit_idx == 3'd0) ? carry : 1'b0;
        end
        return w_bit;
    endfunction

endpackage

`default_nettype wire

// File: rtl/tx_baud_tick.sv
// ============================================================================
// Module      : tx_baud_tick
// Description : Bit-time counter; tick marks the last cycle of each UART bit.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tx_baud_tick #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam logic [7:0] c_last = 8'(CLKS_PER_BIT - 1);

    logic [7:0] r_cnt;

    assign tick = (r_cnt == c_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= 8'd0;
        end else if (clear || tick) begin
            r_cnt <= 8'd0;
        end else begin
            r_cnt <= r_cnt + 8'd1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/uart_tx_suma.sv
// ============================================================================
// Module      : uart_tx_suma
// Description : Sends an adder result {carry, sum} as two 8N1 UART bytes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_tx_suma
    import sumador_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [DATA_BITS-1:0] data_in,
    input  logic                 carry_in,
    input  logic                 valid_in,
    output logic                 ready_out,
    output logic                 tx,
    output logic                 busy
);

    tx_state_t            r_state;
    tx_state_t            w_state_nxt;
    logic                 r_byte_idx;
    logic                 w_byte_nxt;
    logic [2:0]           r_bit_idx;
    logic [2:0]           w_bit_nxt;
    logic [DATA_BITS-1:0] r_data;
    logic [DATA_BITS-1:0] w_data_nxt;
    logic                 r_carry;
    logic                 w_carry_nxt;
    logic                 w_tick;
    logic                 w_clear;
    logic                 w_accept;
    logic                 w_tx;

    // Counter is held at zero while idle so START always begins a fresh bit time.
    assign w_clear  = (r_state == IDLE);
    assign w_accept = valid_in && ready_out;

    tx_baud_tick #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_baud (
        .clk   (clk),
        .rst   (rst),
        .clear (w_clear),
        .tick  (w_tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_byte_idx <= 1'b0;
            r_bit_idx  <= 3'd0;
            r_data     <= '0;
            r_carry    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_byte_idx <= w_byte_nxt;
            r_bit_idx  <= w_bit_nxt;
            r_data     <= w_data_nxt;
            r_carry    <= w_carry_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_byte_nxt  = r_byte_idx;
        w_bit_nxt   = r_bit_idx;
        w_data_nxt  = r_data;
        w_carry_nxt = r_carry;
        w_tx        = 1'b1;

        case (r_state)
            IDLE: begin
                w_tx = 1'b1;
                if (w_accept) begin
                    w_state_nxt = START;
                    w_data_nxt  = data_in;
                    w_carry_nxt = carry_in;
                    w_byte_nxt  = 1'b0;
                    w_bit_nxt   = 3'd0;
                end
            end
            START: begin
                w_tx = 1'b0;
                if (w_tick) begin
                    w_state_nxt = DATA;
                    w_bit_nxt   = 3'd0;
                end
            end
            DATA: begin
                w_tx = payload_bit(r_data, r_carry, r_byte_idx, r_bit_idx);
                if (w_tick) begin
                    if (r_bit_idx == 3'(DATA_BITS - 1)) begin
                        w_state_nxt = STOP;
                        w_bit_nxt   = 3'd0;
                    end else begin
                        w_bit_nxt = r_bit_idx + 3'd1;
                    end
                end
            end
            STOP: begin
                w_tx = 1'b1;
                if (w_tick) begin
                    if (r_byte_idx == 1'(BYTES_PER_FRAME - 1)) begin
                        w_state_nxt = IDLE;
                        w_byte_nxt  = 1'b0;
                    end else begin
                        w_state_nxt = START;
                        w_byte_nxt  = r_byte_idx + 1'b1;
                    end
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_tx        = 1'b1;
            end
        endcase
    end

    // Outputs decode the asynchronously reset state, so reset forces idle immediately.
    assign tx        = w_tx;
    assign ready_out = (r_state == IDLE);
    assign busy      = ~ready_out;

endmodule

`default_nettype wire
